// File: rtl/jk_counter_driver.sv
// rtl/jk_counter_driver.sv - J/K drive stage turning a bank of JK cells into a loadable wrapping up/down counter
//
// Optional feature macro: JK_CNT_MOD_EN
//   defined     : the count wraps at MODULUS-1 and load values above MODULUS-1 are clamped
//   not defined : full binary counter (MAX = 2^WIDTH-1), MODULUS is ignored
//
// Parameters:
//   WIDTH   counter width in bits (>= 1)
//   MODULUS count modulus used only with JK_CNT_MOD_EN (2 <= MODULUS <= 2^WIDTH)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   en     in   count enable
//   up     in   direction, 1 = increment, 0 = decrement
//   load   in   synchronous parallel load (priority over en)
//   din    in   load value
//   q      out  registered count
//   j_vec  out  combinational J drive for the next edge
//   k_vec  out  combinational K drive for the next edge
//   wrap   out  registered one-cycle wrap pulse

module jk_counter_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             wrap
);

`ifdef JK_CNT_MOD_EN
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam int unused_modulus = MODULUS;
`endif

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Load value, clamped into the legal count range.
  always_comb begin
    load_val = din;
`ifdef JK_CNT_MOD_EN
    if (din > MAX) begin
      load_val = MAX;
    end
`endif
  end

  // Drive generation. Priority: rst > load > en > hold.
  // Reset is expressed as a J/K command (j=0, k=1) so that q is only ever
  // updated through the JK characteristic equation.
  always_comb begin
    j_vec     = '0;
    k_vec     = '0;
    target    = q;
    wrap_next = 1'b0;
    if (rst) begin
      k_vec = '1;
    end else if (load) begin
      j_vec = load_val;
      k_vec = ~load_val;
    end else if (en) begin
      if (up) begin
        // A state above MAX (only possible before the first reset) is
        // treated as MAX, so it wraps to 0.
        if (q >= MAX) begin
          target    = '0;
          wrap_next = 1'b1;
        end else begin
          target = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          target    = MAX;
          wrap_next = 1'b1;
        end else begin
          target = q - WIDTH'(1);
        end
      end
      // Toggle form: flip exactly the bits that must change.
      j_vec = target ^ q;
      k_vec = target ^ q;
    end
  end

  // JK characteristic equation, bitwise across the cell bank.
  assign q_next = (j_vec & ~q) | (~k_vec & q);

  always_ff @(posedge clk) begin
    q <= q_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

endmodule
